// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Optional macro PC_ALIGN_CHECK_EN adds a misaligned-target reject path and a 'misaligned' output.
module program_counter_ras #(
   parameter int                ADDR_W     = 32,
   parameter int                OFF_W      = 16,
   parameter int                STEP       = 4,
   parameter int                RAS_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [2:0]                   op,
   input  logic [OFF_W-1:0]             offset,
   input  logic [ADDR_W-1:0]            target,
   output logic [ADDR_W-1:0]            address,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ras_underflow
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic                         misaligned
`endif
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      OP_SEQ    = 3'd0,
      OP_BRANCH = 3'd1,
      OP_JUMP   = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4
   } op_e;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PTR_W-1:0]  sp_q, sp_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   // Stack entries are not reset; sp_q always points at the next slot to write.
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

   logic [ADDR_W-1:0] seq_addr;
   logic [ADDR_W-1:0] offset_ext;
   logic [ADDR_W-1:0] pop_addr;
   logic [ADDR_W-1:0] next_addr;
   logic              do_push, do_pop, do_unf;
   logic              accept;
   logic              push_en;
   logic              stack_full;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
   logic mis_q, mis_d;
`endif

   assign seq_addr   = addr_q + ADDR_W'(STEP);
   assign offset_ext = ADDR_W'($signed(offset));
   assign pop_addr   = ras_mem[sp_q - PTR_W'(1)];
   assign stack_full = (count_q == CNT_W'(RAS_DEPTH));

   always_comb begin
      next_addr = seq_addr;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      do_unf    = 1'b0;
      case (op)
         OP_BRANCH: next_addr = addr_q + offset_ext;
         OP_JUMP:   next_addr = target;
         OP_CALL: begin
            next_addr = target;
            do_push   = 1'b1;
         end
         OP_RET: begin
            if (count_q != '0) begin
               next_addr = pop_addr;
               do_pop    = 1'b1;
            end else begin
               do_unf    = 1'b1;
            end
         end
         default: next_addr = seq_addr;
      endcase
   end

   always_comb begin
      accept  = !stall;
      addr_d  = addr_q;
      sp_d    = sp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
`ifdef PC_ALIGN_CHECK_EN
      mis_d   = 1'b0;
      // A misaligned destination cancels the whole op, including stack side effects.
      if (!stall && ((next_addr & ALIGN_MASK) != '0)) begin
         accept = 1'b0;
         mis_d  = 1'b1;
      end
`endif
      push_en = accept && do_push;
      if (accept) begin
         addr_d = next_addr;
         if (do_push) begin
            sp_d = sp_q + PTR_W'(1);
            if (stack_full) ovf_d = 1'b1;
            else            count_d = count_q + CNT_W'(1);
         end
         if (do_pop) begin
            sp_d    = sp_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
         end
         if (do_unf) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= RESET_ADDR;
         sp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         addr_q  <= addr_d;
         sp_q    <= sp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
`ifdef PC_ALIGN_CHECK_EN
         mis_q   <= mis_d;
`endif
      end
   end

   // When full, sp_q has wrapped onto the oldest entry, so the push overwrites it.
   always_ff @(posedge clk) begin
      if (push_en) ras_mem[sp_q] <= seq_addr;
   end

   assign address       = addr_q;
   assign ras_count     = count_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
`ifdef PC_ALIGN_CHECK_EN
   assign misaligned    = mis_q;
`endif

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed bench for program_counter_ras (default parameters, ADDR_W=32, STEP=4, RAS_DEPTH=4).
module tb_program_counter_ras;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [2:0]  op;
   logic [15:0] offset;
   logic [31:0] target;
   logic [31:0] address;
   logic [2:0]  ras_count;
   logic        ras_overflow;
   logic        ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
   logic        misaligned;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [2:0] SEQ = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3, RET = 3'd4;

   program_counter_ras dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .op            (op),
      .offset        (offset),
      .target        (target),
      .address       (address),
      .ras_count     (ras_count),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .misaligned    (misaligned)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a falling edge: drive the op, let one rising edge pass, return at the next falling edge.
   task automatic step(input logic [2:0] o, input logic [15:0] off, input logic [31:0] tgt);
      op     = o;
      offset = off;
      target = tgt;
      @(posedge clk);
      @(negedge clk);
      $display("[TB] op=%0d off=%h tgt=%h stall=%0b -> address=%h count=%0d ovf=%0b unf=%0b",
               o, off, tgt, stall, address, ras_count, ras_overflow, ras_underflow);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      stall = 1'b0;
      op = SEQ; offset = '0; target = '0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (address !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_address: got %h expected %h", address, 32'h0);
      end
      tests_run++;
      if (ras_count !== 3'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_status: got count=%0d ovf=%0b unf=%0b expected 0/0/0",
                  ras_count, ras_overflow, ras_underflow);
      end
      reset = 1'b1;
   endtask

   task automatic test_seq();
      logic [31:0] exp_addr [3];
      exp_addr[0] = 32'h4; exp_addr[1] = 32'h8; exp_addr[2] = 32'hC;
      for (int i = 0; i < 3; i++) begin
         step(SEQ, 16'h0, 32'h0);
         tests_run++;
         if (address !== exp_addr[i]) begin
            tests_failed++;
            $display("FAIL seq_%0d: got %h expected %h", i, address, exp_addr[i]);
         end
      end
      // Undefined opcode behaves as SEQ.
      step(3'd7, 16'h0, 32'h0);
      tests_run++;
      if (address !== 32'h10) begin
         tests_failed++;
         $display("FAIL seq_op7: got %h expected %h", address, 32'h10);
      end
   endtask

   task automatic test_branch();
      step(JUMP, 16'h0, 32'h20);
      tests_run++;
      if (address !== 32'h20) begin
         tests_failed++;
         $display("FAIL jump_20: got %h expected %h", address, 32'h20);
      end
      step(BRANCH, 16'h000A, 32'h0);
      tests_run++;
      if (address !== 32'h2A) begin
         tests_failed++;
         $display("FAIL branch_fwd: got %h expected %h", address, 32'h2A);
      end
      step(BRANCH, 16'hFFF0, 32'h0);
      tests_run++;
      if (address !== 32'h1A) begin
         tests_failed++;
         $display("FAIL branch_back: got %h expected %h", address, 32'h1A);
      end
   endtask

   task automatic test_call_ret();
      step(JUMP, 16'h0, 32'h100);
      step(CALL, 16'h0, 32'h400);
      tests_run++;
      if (address !== 32'h400 || ras_count !== 3'd1) begin
         tests_failed++;
         $display("FAIL call: got address=%h count=%0d expected 400/1", address, ras_count);
      end
      step(SEQ, 16'h0, 32'h0);
      tests_run++;
      if (address !== 32'h404) begin
         tests_failed++;
         $display("FAIL call_seq: got %h expected %h", address, 32'h404);
      end
      step(RET, 16'h0, 32'h0);
      tests_run++;
      if (address !== 32'h104 || ras_count !== 3'd0) begin
         tests_failed++;
         $display("FAIL ret: got address=%h count=%0d expected 104/0", address, ras_count);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h404; exp_ret[1] = 32'h304; exp_ret[2] = 32'h204; exp_ret[3] = 32'h104;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(CALL, 16'h0, 32'(i * 32'h100));
         tests_run++;
         if (address !== 32'(i * 32'h100) || ras_count !== ((i < 4) ? 3'(i) : 3'd4)
             || ras_overflow !== (i == 5)) begin
            tests_failed++;
            $display("FAIL call_%0d: got address=%h count=%0d ovf=%0b expected %h/%0d/%0b",
                     i, address, ras_count, ras_overflow, 32'(i * 32'h100),
                     (i < 4) ? i : 4, (i == 5));
         end
      end
      for (int i = 0; i < 4; i++) begin
         step(RET, 16'h0, 32'h0);
         tests_run++;
         if (address !== exp_ret[i] || ras_count !== 3'(3 - i) || ras_underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL pop_%0d: got address=%h count=%0d unf=%0b expected %h/%0d/0",
                     i, address, ras_count, ras_underflow, exp_ret[i], 3 - i);
         end
      end
      step(RET, 16'h0, 32'h0);
      tests_run++;
      if (address !== 32'h108 || ras_count !== 3'd0 || ras_underflow !== 1'b1
          || ras_overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL underflow: got address=%h count=%0d unf=%0b ovf=%0b expected 108/0/1/1",
                  address, ras_count, ras_underflow, ras_overflow);
      end
   endtask

   task automatic test_wrap();
      step(JUMP, 16'h0, 32'hFFFF_FFFC);
      step(SEQ, 16'h0, 32'h0);
      tests_run++;
      if (address !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap_seq: got %h expected %h", address, 32'h0);
      end
      step(JUMP, 16'h0, 32'h4);
      step(BRANCH, 16'hFFF8, 32'h0);
      tests_run++;
      if (address !== 32'hFFFF_FFFC) begin
         tests_failed++;
         $display("FAIL wrap_branch: got %h expected %h", address, 32'hFFFF_FFFC);
      end
   endtask

   task automatic test_stall();
      step(JUMP, 16'h0, 32'h200);
      stall = 1'b1;
      step(JUMP, 16'h0, 32'h800);
      tests_run++;
      if (address !== 32'h200) begin
         tests_failed++;
         $display("FAIL stall_jump: got %h expected %h", address, 32'h200);
      end
      step(CALL, 16'h0, 32'h900);
      tests_run++;
      if (address !== 32'h200 || ras_count !== 3'd0) begin
         tests_failed++;
         $display("FAIL stall_call: got address=%h count=%0d expected 200/0", address, ras_count);
      end
      stall = 1'b0;
      step(CALL, 16'h0, 32'h300);
      tests_run++;
      if (address !== 32'h300 || ras_count !== 3'd1) begin
         tests_failed++;
         $display("FAIL after_stall: got address=%h count=%0d expected 300/1", address, ras_count);
      end
   endtask

   task automatic test_async_reset();
      // Flags are still set from the overflow scenario; reset between edges must clear everything.
      op = JUMP; target = 32'h700;
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (address !== 32'h0 || ras_count !== 3'd0 || ras_overflow !== 1'b0
          || ras_underflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: got address=%h count=%0d ovf=%0b unf=%0b expected 0/0/0/0",
                  address, ras_count, ras_overflow, ras_underflow);
      end
      $display("[TB] async reset mid-cycle -> address=%h count=%0d", address, ras_count);
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (address !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_hold: got %h expected %h", address, 32'h0);
      end
      reset = 1'b1;
      step(SEQ, 16'h0, 32'h0);
      tests_run++;
      if (address !== 32'h4) begin
         tests_failed++;
         $display("FAIL post_reset_seq: got %h expected %h", address, 32'h4);
      end
   endtask

`ifdef PC_ALIGN_CHECK_EN
   task automatic test_misaligned();
      step(JUMP, 16'h0, 32'h802);
      tests_run++;
      if (address !== 32'h4 || misaligned !== 1'b1) begin
         tests_failed++;
         $display("FAIL misaligned_jump: got address=%h mis=%0b expected 4/1", address, misaligned);
      end
      step(SEQ, 16'h0, 32'h0);
      tests_run++;
      if (address !== 32'h8 || misaligned !== 1'b0) begin
         tests_failed++;
         $display("FAIL misaligned_pulse: got address=%h mis=%0b expected 8/0", address, misaligned);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_seq();
      test_branch();
      test_call_ret();
      test_overflow();
      test_wrap();
      test_stall();
      test_async_reset();
`ifdef PC_ALIGN_CHECK_EN
      test_misaligned();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/program_counter_ras.md
Name: program_counter_ras

Overview:
Parametrised next-generation program counter for the CPU fetch stage. Each clock it advances by a fixed step, or it applies one of these:
- a signed relative branch
- an absolute jump
- a call, which pushes the return address onto an internal return-address stack (RAS)
- a return, which pops that stack

It drives the instruction-memory address and reports stack status to the control unit.

Parameters:
ADDR_W, 32, width of address and target.
OFF_W, 16, width of signed branch offset (bytes).
STEP, 4, sequential increment in bytes.
RAS_DEPTH, 4, return-stack entries (power of 2, >=2).
RESET_ADDR, 0, address loaded on reset.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
stall  input  1  1 = hold all state this cycle.
op  input  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5-7 treated as SEQ.
offset  input  OFF_W  signed byte offset for BRANCH.
target  input  ADDR_W  absolute destination for JUMP/CALL.
address  output  ADDR_W  current PC (registered).
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
ras_overflow  output  1  sticky: a CALL occurred with the stack full.
ras_underflow  output  1  sticky: a RET occurred with the stack empty.

Behaviour:
- Reset:
  - reset=0 immediately (asynchronously) forces address=RESET_ADDR, ras_count=0, ras_overflow=0, ras_underflow=0, and the stack pointer to 0.
  - Stack entry contents are don't-care after reset.
  - Reset asserted mid-operation aborts any pending op. No partial update is allowed.
- Priority: reset > stall > op. With stall=1, address, stack and flags all hold regardless of op.
- All updates happen on the rising clk edge, so the new address is visible one cycle after op is sampled. There is no combinational path from inputs to address.
- SEQ: address <= address + STEP.
- BRANCH:
  - address <= address + sign_extend(offset) to ADDR_W.
  - Offset is relative to the current address, not address+STEP.
- JUMP: address <= target.
- CALL:
  - Push address+STEP, then address <= target.
  - If ras_count < RAS_DEPTH: ras_count increments.
  - If full: the oldest entry is overwritten (circular buffer), ras_count stays RAS_DEPTH, and ras_overflow is set to 1.
- RET:
  - If ras_count > 0: address <= top entry, and ras_count decrements.
  - If empty: address <= address + STEP (behaves as SEQ) and ras_underflow is set to 1.
- Arithmetic: all address math is modulo 2^ADDR_W. Wrap past all-ones to 0 is silent, and a negative offset below 0 wraps to the top of the address space.
- Sticky flags clear only on reset.
- Stack is LIFO. After an overflow, the most recent RAS_DEPTH return addresses remain poppable in the correct order.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misaligned (1 bit, reset 0).
  - Any computed next address not a multiple of STEP is rejected: address holds, the stack is not modified, and misaligned pulses 1 for exactly one cycle.
  - Assumes STEP is a power of 2.
- When undefined: no misaligned port exists, and every next address is accepted unmodified.

Test Plan:
- Reset 0 then 1, SEQ for 3 cycles (STEP=4) -> address 0x0, 0x4, 0x8, 0xC.
- At address 0x20: BRANCH offset=16'h000A, then BRANCH offset=16'hFFF0 -> address 0x2A, then 0x1A.
- At 0x100: CALL target=0x400, SEQ, RET -> address 0x400, 0x404, 0x104; ras_count 1 then 0.
- Five CALLs (RAS_DEPTH=4) from 0x0, each target = previous+0x100:
  - ras_overflow=1, ras_count=4.
  - Four RETs return the last four pushed addresses in reverse order.
  - A fifth RET sets ras_underflow=1 and performs SEQ.
- At 0xFFFFFFFC: SEQ -> 0x00000000. From 0x4: BRANCH offset=16'hFFF8 -> 0xFFFFFFFC.
- Stall and reset interaction:
  - stall=1 with op=JUMP target=0x800 -> address unchanged.
  - Assert reset mid-cycle between edges -> address=0 before the next edge.
  - With PC_ALIGN_CHECK_EN: JUMP 0x802 -> address holds, misaligned=1 for one cycle.
